// File: rtl/cella_pkg.sv
// Opcodes and sequencer state encodings shared by the CIM array command path.
// Combinational constants only; no latency or backpressure of its own.
package cella_pkg;

  localparam logic [1:0] OP_MAC   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_IDLE  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/array_cmd_seq_if.sv
// Host request/response channel of the array command sequencer.
// Both directions use valid/ready; the host is the master and the sequencer is the slave.
interface array_cmd_seq_if #(
  parameter int ACC_W = 16
);

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [3:0]       req_bank;
  logic [2:0]       req_col;
  logic [15:0]      req_wdata;
  logic [15:0]      req_act;
  logic             req_acc;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ACC_W-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_bank, req_col, req_wdata, req_act, req_acc, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_bank, req_col, req_wdata, req_act, req_acc, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/array_cmd_seq_mac_accum.sv
// Accumulator plus response register; MAC loads or adds res_data, READ passes it through.
// Updates on the sample strobe only (no latency beyond the register); holds otherwise.
module mac_accum
  import cella_pkg::*;
#(
  parameter int RES_W = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample,
  input  logic             is_mac,
  input  logic             acc_en,
  input  logic [RES_W-1:0] res_data,
  output logic [ACC_W-1:0] rsp_data
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] res_ext;
  logic [ACC_W-1:0] sum;

  assign res_ext = ACC_W'(res_data);
  // Wraps modulo 2^ACC_W by construction of the adder width.
  assign sum     = acc_en ? (acc + res_ext) : res_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      rsp_data <= '0;
    end else if (sample) begin
      if (is_mac) begin
        acc      <= sum;
        rsp_data <= sum;
      end else begin
        rsp_data <= res_ext;
      end
    end
  end

endmodule

// File: rtl/array_cmd_seq.sv
// Command initiator for array_ctrl: one command at a time, 2 drive cycles then RES_LAT wait; response held until rsp_ready.
// req_ready only in IDLE. Optional accumulator under `define MAC_ACC_EN.
module array_cmd_seq
  import cella_pkg::*;
#(
  parameter int RES_W   = 8,
  parameter int ACC_W   = 16,
  parameter int RES_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  array_cmd_seq_if.slave   host,
  output logic [1:0]       op_code,
  output logic [3:0]       addr_bank,
  output logic [2:0]       addr_col,
  output logic [15:0]      data_bank,
  output logic [15:0]      data_in,
  input  logic [RES_W-1:0] res_data,
  output logic             busy
);

  localparam logic [3:0] LAST_CNT = 4'(RES_LAT - 1);

  seq_state_t       state;
  logic [1:0]       op_q;
  logic [3:0]       cnt;
  logic             rsp_valid_q;
  logic [ACC_W-1:0] rsp_data_q;
  logic             sample;

  assign host.req_ready = (state == ST_IDLE) && !rst;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;
  assign busy           = (state != ST_IDLE);
  assign sample         = (state == ST_WAIT) && (cnt == LAST_CNT);

`ifdef MAC_ACC_EN
  logic acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 1'b0;
    end else if (host.req_valid && host.req_ready && host.req_op != OP_IDLE) begin
      acc_q <= host.req_acc;
    end
  end

  mac_accum #(
    .RES_W (RES_W),
    .ACC_W (ACC_W)
  ) u_mac_accum (
    .clk      (clk),
    .rst      (rst),
    .sample   (sample),
    .is_mac   (op_q == OP_MAC),
    .acc_en   (acc_q),
    .res_data (res_data),
    .rsp_data (rsp_data_q)
  );
`else
  logic unused_req_acc;
  assign unused_req_acc = host.req_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_q <= '0;
    end else if (sample) begin
      rsp_data_q <= ACC_W'(res_data);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= OP_IDLE;
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      op_code     <= OP_IDLE;
      addr_bank   <= '0;
      addr_col    <= '0;
      data_bank   <= '0;
      data_in     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // NOP is consumed here with no array activity and no response.
          if (host.req_valid && host.req_op != OP_IDLE) begin
            state     <= ST_SETUP;
            op_q      <= host.req_op;
            op_code   <= host.req_op;
            addr_bank <= '0;
            addr_col  <= '0;
            data_bank <= '0;
            data_in   <= '0;
            case (host.req_op)
              OP_MAC: begin
                data_bank <= host.req_wdata;
                data_in   <= host.req_act;
              end
              OP_WRITE: begin
                addr_bank <= host.req_bank;
                data_bank <= {8'h00, host.req_wdata[7:0]};
              end
              default: begin
                addr_col  <= host.req_col;
                data_bank <= {12'h000, host.req_wdata[3:0]};
              end
            endcase
          end
        end
        ST_SETUP: state <= ST_EXEC;
        ST_EXEC: begin
          cnt <= '0;
          if (op_q == OP_WRITE) begin
            state     <= ST_IDLE;
            op_code   <= OP_IDLE;
            addr_bank <= '0;
            addr_col  <= '0;
            data_bank <= '0;
            data_in   <= '0;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == LAST_CNT) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            op_code     <= OP_IDLE;
            addr_bank   <= '0;
            addr_col    <= '0;
            data_bank   <= '0;
            data_in     <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_RESP: begin
          if (host.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_cmd_seq.sv
// Directed bench for array_cmd_seq: write/read/mac timing and masking, response stall, reset mid-op, NOP.
module tb_array_cmd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  op_code;
  logic [3:0]  addr_bank;
  logic [2:0]  addr_col;
  logic [15:0] data_bank;
  logic [15:0] data_in;
  logic [7:0]  res_data;
  logic        busy;
  int          checks = 0;
  int          failures = 0;

  array_cmd_seq_if #(.ACC_W(16)) host_if ();

  array_cmd_seq #(.RES_W(8), .ACC_W(16), .RES_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (host_if),
    .op_code   (op_code),
    .addr_bank (addr_bank),
    .addr_col  (addr_col),
    .data_bank (data_bank),
    .data_in   (data_in),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [1:0] op, input logic [3:0] bank, input logic [2:0] col,
                     input logic [15:0] wdata, input logic [15:0] act, input logic acc);
    host_if.req_valid = 1'b1;
    host_if.req_op    = op;
    host_if.req_bank  = bank;
    host_if.req_col   = col;
    host_if.req_wdata = wdata;
    host_if.req_act   = act;
    host_if.req_acc   = acc;
  endtask

  initial begin
    rst = 1'b1;
    res_data = 8'h00;
    host_if.rsp_ready = 1'b0;
    req(2'b11, 4'h0, 3'd0, 16'h0, 16'h0, 1'b0);
    host_if.req_valid = 1'b0;
    cyc(); cyc();
    chk("rst_op", op_code, 2'b11);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rspv", host_if.rsp_valid, 1'b0);
    chk("rst_rspd", host_if.rsp_data, 16'h0);
    chk("rst_rdy", host_if.req_ready, 1'b0);
    chk("rst_dbank", data_bank, 16'h0);
    rst = 1'b0;
    #1;
    chk("idle_rdy", host_if.req_ready, 1'b1);

    // WRITE: unused col/act must be masked off
    req(2'b01, 4'hA, 3'd7, 16'h12C3, 16'hFFFF, 1'b0);
    cyc();
    host_if.req_valid = 1'b0;
    chk("wr_s_op", op_code, 2'b01);
    chk("wr_s_bank", addr_bank, 4'hA);
    chk("wr_s_col", addr_col, 3'd0);
    chk("wr_s_dbank", data_bank, 16'h00C3);
    chk("wr_s_din", data_in, 16'h0);
    chk("wr_s_rdy", host_if.req_ready, 1'b0);
    chk("wr_s_busy", busy, 1'b1);
    cyc();
    chk("wr_e_op", op_code, 2'b01);
    chk("wr_e_dbank", data_bank, 16'h00C3);
    cyc();
    chk("wr_i_op", op_code, 2'b11);
    chk("wr_i_dbank", data_bank, 16'h0);
    chk("wr_i_rdy", host_if.req_ready, 1'b1);
    chk("wr_i_rspv", host_if.rsp_valid, 1'b0);

    // READ: rsp_ready held high throughout, only the RESP handshake counts
    host_if.rsp_ready = 1'b1;
    res_data = 8'h11;
    req(2'b10, 4'hF, 3'd5, 16'hFFF6, 16'hAAAA, 1'b0);
    cyc();
    host_if.req_valid = 1'b0;
    chk("rd_s_op", op_code, 2'b10);
    chk("rd_s_col", addr_col, 3'd5);
    chk("rd_s_bank", addr_bank, 4'h0);
    chk("rd_s_dbank", data_bank, 16'h0006);
    chk("rd_s_din", data_in, 16'h0);
    cyc(); cyc();
    chk("rd_w0_op", op_code, 2'b10);
    chk("rd_w0_rspv", host_if.rsp_valid, 1'b0);
    cyc();
    res_data = 8'h5A;
    chk("rd_w1_col", addr_col, 3'd5);
    chk("rd_w1_rspv", host_if.rsp_valid, 1'b0);
    cyc();
    res_data = 8'h22;
    chk("rd_r_rspv", host_if.rsp_valid, 1'b1);
    chk("rd_r_rspd", host_if.rsp_data, 16'h005A);
    chk("rd_r_op", op_code, 2'b11);
    chk("rd_r_col", addr_col, 3'd0);
    chk("rd_r_busy", busy, 1'b1);
    cyc();
    chk("rd_done_rspv", host_if.rsp_valid, 1'b0);
    chk("rd_done_rdy", host_if.req_ready, 1'b1);

    // MAC with response stalled three cycles
    host_if.rsp_ready = 1'b0;
    req(2'b00, 4'h3, 3'd2, 16'hF0F0, 16'h00FF, 1'b0);
    cyc();
    host_if.req_valid = 1'b0;
    chk("mac_s_op", op_code, 2'b00);
    chk("mac_s_dbank", data_bank, 16'hF0F0);
    chk("mac_s_din", data_in, 16'h00FF);
    chk("mac_s_bank", addr_bank, 4'h0);
    chk("mac_s_col", addr_col, 3'd0);
    cyc(); cyc(); cyc();
    res_data = 8'h77;
    chk("mac_w1_din", data_in, 16'h00FF);
    cyc();
    res_data = 8'h33;
    req(2'b01, 4'h1, 3'd0, 16'h0011, 16'h0, 1'b0);
    chk("mac_r_rspd", host_if.rsp_data, 16'h0077);
    chk("mac_r_din", data_in, 16'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mac_stall_rspv", host_if.rsp_valid, 1'b1);
      chk("mac_stall_rspd", host_if.rsp_data, 16'h0077);
      chk("mac_stall_rdy", host_if.req_ready, 1'b0);
      chk("mac_stall_op", op_code, 2'b11);
    end
    host_if.req_valid = 1'b0;
    host_if.rsp_ready = 1'b1;
    cyc();
    chk("mac_done_rspv", host_if.rsp_valid, 1'b0);
    chk("mac_done_rdy", host_if.req_ready, 1'b1);

    // Reset asserted during WAIT drops the pending response
    res_data = 8'h99;
    req(2'b10, 4'h0, 3'd1, 16'h0003, 16'h0, 1'b0);
    cyc();
    host_if.req_valid = 1'b0;
    cyc(); cyc();
    chk("rw_wait_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rw_rdy_in_rst", host_if.req_ready, 1'b0);
    cyc();
    rst = 1'b0;
    chk("rw_op", op_code, 2'b11);
    chk("rw_busy", busy, 1'b0);
    chk("rw_col", addr_col, 3'd0);
    chk("rw_rspv", host_if.rsp_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rw_no_rsp", host_if.rsp_valid, 1'b0);
    end

    // NOP: no drive, stays ready
    req(2'b11, 4'hF, 3'd7, 16'hFFFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("nop_op", op_code, 2'b11);
      chk("nop_busy", busy, 1'b0);
      chk("nop_rdy", host_if.req_ready, 1'b1);
      chk("nop_dbank", data_bank, 16'h0);
    end
    host_if.req_valid = 1'b0;

    // Back-to-back WRITEs issue every 3 cycles
    req(2'b01, 4'h5, 3'd0, 16'h00AB, 16'h0, 1'b0);
    cyc();
    chk("b2b_s1_op", op_code, 2'b01);
    cyc(); cyc();
    chk("b2b_gap_op", op_code, 2'b11);
    cyc();
    host_if.req_valid = 1'b0;
    chk("b2b_s2_op", op_code, 2'b01);
    chk("b2b_s2_bank", addr_bank, 4'h5);
    cyc(); cyc();
    chk("b2b_end_rdy", host_if.req_ready, 1'b1);

`ifdef MAC_ACC_EN
    res_data = 8'h80;
    req(2'b00, 4'h0, 3'd0, 16'h1, 16'h1, 1'b0);
    cyc();
    host_if.req_valid = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("acc_first", host_if.rsp_data, 16'h0080);
    cyc();
    res_data = 8'h90;
    req(2'b00, 4'h0, 3'd0, 16'h1, 16'h1, 1'b1);
    cyc();
    host_if.req_valid = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("acc_second", host_if.rsp_data, 16'h0110);
    cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
